// File: rtl/digit_scan.sv
// -----------------------------------------------------------------------------
// digit_scan -- four-digit multiplexed seven-segment scanner.
//
// Each digit is lit for DWELL rising edges of the slow scan clock clk_1K. One
// dark cycle separates consecutive digits to stop ghosting. Display values
// come from shadow registers that are reloaded only at the start of a frame
// (entry to digit0), so the four digits of a frame always belong together.
//
// Parameters
//   DWELL  clk_1K rises per digit, 1..255
//   LZB    leading-zero blanking enable
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous reset, active-low
//   clk_1K  in   slow scan clock level; sampled, never used as a clock
//   data    in   16  four hex digits, digit0 = data[3:0]
//   dp_in   in   4   decimal points, active-high, bit i -> digit i
//   an      out  4   anode enables, active-low
//   seg     out  8   segments {dp,g,f,e,d,c,b,a}, active-low
//   frame   out  1   one-cycle pulse when a new frame starts
// -----------------------------------------------------------------------------
module digit_scan #(
    parameter logic [7:0] DWELL = 8'd1,
    parameter logic       LZB   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_1K,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame
);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    // Segment pattern (g..a, active-low) for one hex nibble.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Full segment byte for digit i, including leading-zero blanking and dp.
    // A digit is a leading zero when it and every higher digit are zero;
    // digit0 is always shown so a zero value still reads "0".
    function automatic logic [7:0] digit_seg(input logic [15:0] d,
                                             input logic [3:0]  dp,
                                             input logic [1:0]  i);
        logic       blank;
        logic [6:0] s;
        case (i)
            2'd3:    blank = (d[15:12] == 4'h0);
            2'd2:    blank = (d[15:8]  == 8'h00);
            2'd1:    blank = (d[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
        s = (blank && LZB) ? 7'h7F : hex_seg(d[{i, 2'b00} +: 4]);
        return {~dp[i], s};
    endfunction

    // Stage p0/p1: two-flop synchroniser; p2: history flop for edge detect.
    logic sync_p0, sync_p1, hist_p2;
    logic tick;

    assign tick = sync_p1 & ~hist_p2;

    logic [0:0]  state_q, state_n;
    logic [1:0]  idx_q, idx_n;
    logic [7:0]  cnt_q, cnt_n;
    logic [15:0] shd_data_q, shd_data_n;
    logic [3:0]  shd_dp_q, shd_dp_n;
    logic        start_q, start_n;
    logic        frame_n;
    logic [3:0]  an_n;
    logic [7:0]  seg_n;

    // Scan sequencing. start_q marks the BLANK that follows reset: idx rests
    // at 3 during reset but the first digit shown afterwards must be digit0.
    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        cnt_n      = cnt_q;
        shd_data_n = shd_data_q;
        shd_dp_n   = shd_dp_q;
        start_n    = start_q;
        frame_n    = 1'b0;
        if (state_q == ST_SHOW) begin
            if (tick) begin
                if (cnt_q == DWELL - 8'd1) begin
                    cnt_n   = 8'd0;
                    idx_n   = idx_q + 2'd1;
                    state_n = ST_BLANK;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
        end else begin
            // BLANK is a single cycle; any tick seen here is simply ignored.
            state_n = ST_SHOW;
            if (start_q) begin
                idx_n   = 2'd0;
                start_n = 1'b0;
            end
            if (idx_n == 2'd0) begin
                shd_data_n = data;
                shd_dp_n   = dp_in;
                frame_n    = 1'b1;
            end
        end
    end

    // Outputs are decoded from next-state values and then registered, so they
    // line up with the state register and have no path from the input pins.
    always_comb begin
        an_n  = 4'hF;
        seg_n = 8'hFF;
        if (state_n == ST_SHOW) begin
            an_n  = ~(4'b0001 << idx_n);
            seg_n = digit_seg(shd_data_n, shd_dp_n, idx_n);
        end
    end

    // Stage p3: state and registered outputs.
    // Synchroniser flops reset high because the divider holds clk_1K high
    // during reset; a low reset value would fake a rise on release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            hist_p2    <= 1'b1;
            state_q    <= ST_BLANK;
            idx_q      <= 2'd3;
            cnt_q      <= 8'd0;
            shd_data_q <= 16'h0000;
            shd_dp_q   <= 4'h0;
            start_q    <= 1'b1;
            an         <= 4'hF;
            seg        <= 8'hFF;
            frame      <= 1'b0;
        end else begin
            sync_p0    <= clk_1K;
            sync_p1    <= sync_p0;
            hist_p2    <= sync_p1;
            state_q    <= state_n;
            idx_q      <= idx_n;
            cnt_q      <= cnt_n;
            shd_data_q <= shd_data_n;
            shd_dp_q   <= shd_dp_n;
            start_q    <= start_n;
            an         <= an_n;
            seg        <= seg_n;
            frame      <= frame_n;
        end
    end

endmodule

// File: tb/tb_digit_scan.sv
// -----------------------------------------------------------------------------
// tb_digit_scan -- scoreboard bench for digit_scan.
// Two instances share stimulus: dut_a (DWELL=1, LZB=0) and dut_b (DWELL=3,
// LZB=1). The stimulus pushes the expected digit sequence into a queue; the
// monitor watches the selected instance and, each time a lit digit goes dark,
// pops one entry and compares anode, segments, frame pulses and lit length.
// -----------------------------------------------------------------------------
module tb_digit_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_1K;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  an_a, an_b;
    logic [7:0]  seg_a, seg_b;
    logic        frame_a, frame_b;

    always #5 clk = ~clk;

    digit_scan #(.DWELL(8'd1), .LZB(1'b0)) dut_a (
        .clk(clk), .reset(reset), .clk_1K(clk_1K), .data(data), .dp_in(dp_in),
        .an(an_a), .seg(seg_a), .frame(frame_a)
    );

    digit_scan #(.DWELL(8'd3), .LZB(1'b1)) dut_b (
        .clk(clk), .reset(reset), .clk_1K(clk_1K), .data(data), .dp_in(dp_in),
        .an(an_b), .seg(seg_b), .frame(frame_b)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        int         frames;
        int         len;     // lit cycles; 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;
    logic sel    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic expect_digit(input logic [3:0] a, input logic [7:0] s,
                                input int f, input int len);
        exp_t e;
        e.an = a; e.seg = s; e.frames = f; e.len = len;
        exp_q.push_back(e);
    endtask

    // Monitor
    logic       lit = 1'b0;
    logic       fresh = 1'b1;
    int         len_cnt = 0;
    int         dark_cnt = 0;
    int         frame_cnt = 0;
    logic [3:0] cur_an;
    logic [7:0] cur_seg;

    always @(negedge clk) begin
        logic [3:0] a;
        logic [7:0] s;
        logic       f;
        exp_t       want_e;
        a = sel ? an_b    : an_a;
        s = sel ? seg_b   : seg_a;
        f = sel ? frame_b : frame_a;
        if (!mon_en) begin
            lit   = 1'b0;
            fresh = 1'b1;
        end else if (a != 4'hF) begin
            if (!lit) begin
                if (!fresh) chk("dark_cycles", dark_cnt, 1);
                fresh     = 1'b0;
                lit       = 1'b1;
                len_cnt   = 0;
                frame_cnt = 0;
                cur_an    = a;
                cur_seg   = s;
            end
            len_cnt++;
            if (f) frame_cnt++;
        end else begin
            if (lit) begin
                chk("queue_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    want_e = exp_q.pop_front();
                    chk("an", cur_an, want_e.an);
                    chk("seg", cur_seg, want_e.seg);
                    chk("frame_pulses", frame_cnt, want_e.frames);
                    if (want_e.len != 0) chk("lit_cycles", len_cnt, want_e.len);
                end
                lit      = 1'b0;
                dark_cnt = 0;
            end
            dark_cnt++;
            chk("dark_frame_seg", {f, s}, 9'h0FF);
            if (!reset) fresh = 1'b1;
        end
    end

    // clk_1K period of 4 clk cycles; optional glitch too short to be sampled.
    task automatic run_ticks(input int n, input bit glitch);
        for (int k = 0; k < n; k++) begin
            clk_1K = 1'b1;
            repeat (2) @(negedge clk);
            clk_1K = 1'b0;
            if (glitch) begin
                #1 clk_1K = 1'b1;
                #2 clk_1K = 1'b0;
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic do_reset(input logic [15:0] d, input logic [3:0] dp);
        mon_en = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        clk_1K = 1'b1;
        data   = d;
        dp_in  = dp;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        reset  = 1'b1;
        clk_1K = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        clk_1K = 1'b1;
        data   = 16'h0000;
        dp_in  = 4'h0;
        #2 reset = 1'b0;
        #1;
        chk("rst_an_a", an_a, 4'hF);
        chk("rst_seg_a", seg_a, 8'hFF);
        chk("rst_frame_a", frame_a, 1'b0);
        chk("rst_an_b", an_b, 4'hF);
        chk("rst_seg_b", seg_b, 8'hFF);
        chk("rst_frame_b", frame_b, 1'b0);

        // Basic scan, DWELL=1, data 1234
        sel = 1'b0;
        exp_q.delete();
        expect_digit(4'hE, 8'h99, 1, 0);
        expect_digit(4'hD, 8'hB0, 0, 3);
        expect_digit(4'hB, 8'hA4, 0, 3);
        expect_digit(4'h7, 8'hF9, 0, 3);
        expect_digit(4'hE, 8'h99, 1, 3);
        do_reset(16'h1234, 4'h0);
        run_ticks(5, 1'b0);
        mon_en = 1'b0;
        chk("queue_empty_basic", exp_q.size(), 0);

        // DWELL=3 with leading-zero blanking and unsampled glitches
        sel = 1'b1;
        exp_q.delete();
        expect_digit(4'hE, 8'hC0, 1, 0);
        expect_digit(4'hD, 8'h92, 0, 11);
        expect_digit(4'hB, 8'hFF, 0, 11);
        expect_digit(4'h7, 8'hFF, 0, 11);
        expect_digit(4'hE, 8'hC0, 1, 11);
        do_reset(16'h0050, 4'h0);
        run_ticks(15, 1'b1);
        data = 16'h0000;
        expect_digit(4'hD, 8'h92, 0, 11);
        expect_digit(4'hB, 8'hFF, 0, 11);
        expect_digit(4'h7, 8'hFF, 0, 11);
        expect_digit(4'hE, 8'hC0, 1, 11);
        expect_digit(4'hD, 8'hFF, 0, 11);
        expect_digit(4'hB, 8'hFF, 0, 11);
        run_ticks(18, 1'b1);
        mon_en = 1'b0;
        chk("queue_empty_lzb", exp_q.size(), 0);

        // Mid-frame data change and decimal point on digit2
        sel = 1'b0;
        exp_q.delete();
        expect_digit(4'hE, 8'hF9, 1, 0);
        expect_digit(4'hD, 8'hF9, 0, 3);
        do_reset(16'h1111, 4'b0100);
        run_ticks(2, 1'b0);
        data  = 16'hAAAA;
        dp_in = 4'b0000;
        expect_digit(4'hB, 8'h79, 0, 3);
        expect_digit(4'h7, 8'hF9, 0, 3);
        expect_digit(4'hE, 8'h88, 1, 3);
        expect_digit(4'hD, 8'h88, 0, 3);
        expect_digit(4'hB, 8'h88, 0, 3);
        expect_digit(4'h7, 8'h88, 0, 3);
        run_ticks(6, 1'b0);
        mon_en = 1'b0;
        chk("queue_empty_shadow", exp_q.size(), 0);

        // Reset pulsed while digit2 is mid-dwell on dut_b
        sel = 1'b1;
        exp_q.delete();
        expect_digit(4'hE, 8'h99, 1, 0);
        expect_digit(4'hD, 8'hB0, 0, 11);
        expect_digit(4'hB, 8'hA4, 0, 0);
        do_reset(16'h1234, 4'h0);
        run_ticks(7, 1'b0);
        chk("pre_reset_an_b", an_b, 4'hB);
        #1 reset = 1'b0;
        #1;
        chk("async_an_b", an_b, 4'hF);
        chk("async_seg_b", seg_b, 8'hFF);
        chk("async_frame_b", frame_b, 1'b0);
        chk("async_an_a", an_a, 4'hF);
        repeat (3) @(negedge clk);
        expect_digit(4'hE, 8'h99, 1, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run_ticks(3, 1'b0);
        mon_en = 1'b0;
        chk("queue_empty_restart", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
